// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_scheduler
// Purpose  : Round-robin scheduler sharing one 4-bit ALU between NREQ
//            requesters. Operands are held on the ALU for ALU_LAT cycles,
//            then result/flags are returned tagged with the requester index.
//            Optional starvation monitor: define ALU_RR_SCHED_STARVE_MON_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
    parameter  int NREQ         = 4,
    parameter  int ALU_LAT      = 6,
    parameter  int STARVE_LIMIT = 64,
    localparam int IDW          = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    input  logic [2*NREQ-1:0] req_op,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [1:0]        alu_op,
    input  logic [3:0]        alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              busy,
    output logic [NREQ-1:0]   starve_flag
);

    localparam int CNTW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [CNTW-1:0] hold_cnt;
    logic            hold_done;
    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    scan;

    assign hold_done = (hold_cnt == CNTW'(ALU_LAT - 1));
    assign busy      = (state != IDLE);

    // Winner search: scan downward so the lowest rotation offset from rr_ptr wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (req_valid[scan[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan[IDW-1:0];
            end
        end
    end

    // One-hot accept strobe, only offered while idle
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; in RESP rsp_valid is always high, so rsp_ready alone completes
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_vld) state_next = HOLD;
            HOLD:    if (hold_done) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch on accept, hold counter, response capture/release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            hold_cnt     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        alu_a    <= req_a[4*grant_idx +: 4];
                        alu_b    <= req_b[4*grant_idx +: 4];
                        alu_op   <= req_op[2*grant_idx +: 2];
                        rsp_id   <= grant_idx;
                        rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_done) begin
                        rsp_result   <= alu_result;
                        rsp_carry    <= alu_carry;
                        rsp_zero     <= alu_zero;
                        rsp_overflow <= alu_overflow;
                        rsp_valid    <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_RR_SCHED_STARVE_MON_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_starve
        logic [7:0] wait_cnt;
        logic       flag;

        // Saturating wait counter; flag is sticky once the limit is reached
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wait_cnt <= '0;
                flag     <= 1'b0;
            end else begin
                if (!req_valid[i] || req_ready[i]) begin
                    wait_cnt <= '0;
                end else if (wait_cnt != 8'hFF) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                if (wait_cnt == 8'(STARVE_LIMIT)) begin
                    flag <= 1'b1;
                end
            end
        end

        assign starve_flag[i] = flag;
    end
`else
    // No monitor: flags tied low; the limit is still qualified so both builds
    // accept the same parameter set.
    localparam logic LIMIT_IN_RANGE = (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 255);
    assign starve_flag = {NREQ{1'b0 & LIMIT_IN_RANGE}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_scheduler
// Purpose  : Directed self-checking bench for alu_rr_scheduler with a
//            behavioural 4-bit ALU attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [2*NREQ-1:0] req_op;
    logic [3:0]      alu_a;
    logic [3:0]      alu_b;
    logic [1:0]      alu_op;
    logic [3:0]      alu_result;
    logic            alu_carry;
    logic            alu_zero;
    logic            alu_overflow;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [3:0]      rsp_result;
    logic            rsp_carry;
    logic            rsp_zero;
    logic            rsp_overflow;
    logic            busy;
    logic [NREQ-1:0] starve_flag;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

`ifdef ALU_RR_SCHED_STARVE_MON_EN
    localparam logic [NREQ-1:0] EXP_STARVE = 4'b0100;
`else
    localparam logic [NREQ-1:0] EXP_STARVE = 4'b0000;
`endif

    alu_rr_scheduler #(
        .NREQ         (NREQ),
        .ALU_LAT      (6),
        .STARVE_LIMIT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .busy         (busy),
        .starve_flag  (starve_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: add/sub carry is bit 4 of the 5-bit result (borrow for sub)
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum      = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            2'b00: begin
                alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_overflow = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
            end
            2'b01: begin
                alu_sum      = {1'b0, alu_a} - {1'b0, alu_b};
                alu_overflow = (alu_a[3] != alu_b[3]) && (alu_sum[3] != alu_a[3]);
            end
            2'b10:   alu_sum = {1'b0, alu_a & alu_b};
            default: alu_sum = {1'b0, alu_a | alu_b};
        endcase
        alu_result = alu_sum[3:0];
        alu_carry  = alu_sum[4];
        alu_zero   = (alu_sum[3:0] == 4'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op);
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_op[2*i +: 2] = op;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (req_ready == '0 && w < 30) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic wait_rsp();
        int w = 0;
        while (!rsp_valid && w < 30) begin
            @(negedge clk);
            w++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    logic [3:0]      exp_res [4];
    logic [NREQ-1:0] onehot;
    int              lat;
    int              prev;
    logic            seen;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        chk("rst_rsp", {rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow}, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_starve", starve_flag, 0);
        rst = 1'b0;

        // Single request: requester 1, 3 + 4
        set_req(1, 4'h3, 4'h4, 2'b00);
        req_valid = 4'b0010;
        #1;
        chk("single_ready", req_ready, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        chk("single_busy", busy, 1);
        chk("single_alu", {alu_a, alu_b, alu_op}, {4'h3, 4'h4, 2'b00});
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("single_latency", lat, 6);
        chk("single_id", rsp_id, 1);
        chk("single_result", rsp_result, 4'h7);
        chk("single_flags", {rsp_carry, rsp_zero, rsp_overflow}, 3'b000);
        @(posedge clk);
        @(negedge clk);
        chk("single_done", {rsp_valid, busy}, 2'b00);

        // Reset mid-stream, then contention with all four valid
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_req(0, 4'h9, 4'h4, 2'b00);
        set_req(1, 4'h5, 4'h7, 2'b01);
        set_req(2, 4'hC, 4'hA, 2'b10);
        set_req(3, 4'h3, 4'h4, 2'b11);
        exp_res[0] = 4'hD;
        exp_res[1] = 4'hE;
        exp_res[2] = 4'h8;
        exp_res[3] = 4'h7;
        req_valid  = 4'b1111;
        #1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ready();
            onehot = 4'b0001 << (k % 4);
            chk($sformatf("cont_grant%0d", k), req_ready, onehot);
            if (k > 0) chk($sformatf("cont_gap%0d", k), cyc - prev, 8);
            prev = cyc;
            wait_rsp();
            chk($sformatf("cont_id%0d", k), rsp_id, k % 4);
            chk($sformatf("cont_res%0d", k), rsp_result, exp_res[k % 4]);
        end
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);

        // Backpressure with F + 1: result 0, carry 1, zero 1
        rsp_ready = 1'b0;
        set_req(1, 4'hF, 4'h1, 2'b00);
        req_valid = 4'b0011;
        #1;
        chk("bp_grant", req_ready, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i),
                {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_overflow, req_ready},
                {1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 4'b0000});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_no_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_released", rsp_valid, 0);
        chk("bp_next_grant", req_ready, 4'b0001);
        req_valid = '0;

        // Reset two cycles into HOLD
        set_req(3, 4'h9, 4'h9, 2'b01);
        req_valid = 4'b1000;
        #1;
        chk("mh_grant", req_ready, 4'b1000);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        chk("mh_alu_a", alu_a, 4'h9);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mh_alu", {alu_a, alu_b, alu_op}, 0);
        chk("mh_state", {busy, rsp_valid}, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mh_no_rsp", seen, 0);
        req_valid = 4'b1111;
        #1;
        chk("mh_grant0", req_ready, 4'b0001);
        req_valid = '0;

        // Starvation: requester 2 waits while requester 0 is stalled in RESP
        @(negedge clk);
        set_req(0, 4'h1, 4'h1, 2'b00);
        set_req(2, 4'h2, 4'h2, 2'b00);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0100;
        wait_rsp();
        repeat (20) @(negedge clk);
        chk("starve_set", starve_flag, EXP_STARVE);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("starve_grant2", req_ready, 4'b0100);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        chk("starve_served", {busy, alu_a}, {1'b1, 4'h2});
        chk("starve_sticky", starve_flag, EXP_STARVE);
        wait_rsp();
        chk("starve_rsp", {rsp_id, rsp_result}, {2'd2, 4'h4});
        @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares one 4-bit ALU between `NREQ` requesters. It accepts one operation at a time over a valid/ready handshake and holds the operands stable on the ALU inputs for a fixed `ALU_LAT` window. It then captures the ALU result and flags and returns them, tagged with the requester index, over a valid/ready response channel. It sits between the requesting agents and the ALU instance; the ALU's own phase sequencing stays internal to the ALU.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ALU_LAT`, 6: cycles the operands are held before the ALU outputs are sampled, ≥1. The default covers a free-running 3-phase ALU plus its registered writeback.
- `STARVE_LIMIT`, 64: wait cycles before a starvation flag sets, 1..255. Used only with the macro.
- `IDW`: derived as `$clog2(NREQ)`; not overridable.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `req_a`, `req_b`  in  4*NREQ  operands; requester i uses bits [4i+3:4i].
- `req_op`  in  2*NREQ  opcode; requester i uses bits [2i+1:2i]. Encoding: 00 add, 01 sub, 10 and, 11 or.
- `alu_a`, `alu_b`  out  4  registered operands to the ALU.
- `alu_op`  out  2  registered opcode to the ALU.
- `alu_result`  in  4  ALU result.
- `alu_carry`, `alu_zero`, `alu_overflow`  in  1 each  ALU flags.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  IDW  index of the requester the response belongs to.
- `rsp_result`  out  4  captured result.
- `rsp_carry`, `rsp_zero`, `rsp_overflow`  out  1 each  captured flags.
- `busy`  out  1  high whenever the state is not IDLE.
- `starve_flag`  out  NREQ  sticky starvation flags.

## Operation
- The FSM has three states: IDLE, HOLD, RESP.
- **IDLE**
  - If any `req_valid` bit is set, the winner g is the first set bit scanning upward from `rr_ptr`, wrapping modulo NREQ.
  - `req_ready[g]` is asserted combinationally in IDLE only.
  - On the edge that accepts g:
    - latch g's operands into `alu_a`/`alu_b`/`alu_op`;
    - set `rsp_id`=g;
    - set `rr_ptr` = (g+1) mod NREQ;
    - clear `hold_cnt`;
    - go to HOLD.
- **HOLD**
  - `hold_cnt` increments every cycle.
  - On the edge where `hold_cnt`==ALU_LAT-1:
    - capture `alu_result` and the three ALU flags into the `rsp_*` registers;
    - set `rsp_valid`=1;
    - go to RESP.
  - `req_ready` is all zeros.
- **RESP**
  - `rsp_valid` and all `rsp_*` outputs are held stable until `rsp_valid`&&`rsp_ready`.
  - On that edge: `rsp_valid`=0 and the state returns to IDLE.
  - `req_ready` is all zeros.
- `alu_*` outputs keep the last accepted operands outside HOLD; they are not cleared.
- A requester may drop `req_valid` at any time while it is not granted. Its request is then ignored.
- `rsp_ready` is ignored outside RESP.

Reset values:
- state IDLE;
- `rr_ptr`=0;
- all `alu_*`, `rsp_*` outputs and `hold_cnt` = 0;
- `rsp_valid`=0, `busy`=0;
- `starve_flag`=0.

## Timing
- Accept edge t → `rsp_valid` is high after edge t+ALU_LAT.
- With `rsp_ready`=1, the response completes at edge t+ALU_LAT+1. The earliest next accept is edge t+ALU_LAT+2.
- Peak throughput is one operation per ALU_LAT+2 cycles.
- Under contention, grants follow strict rotation: after granting g, g has the lowest priority at the next arbitration.
- `rst` asserted in any state, including mid-HOLD or mid-RESP:
  - all outputs go to their reset values immediately (asynchronous);
  - the in-flight operation is dropped and no response is produced;
  - `rr_ptr` returns to 0.
- Deassertion of `rst` is synchronized externally. The first accept can occur on the first clock edge after deassertion.

## Configuration
- Macro: `ALU_RR_SCHED_STARVE_MON_EN`.
- **Defined:** one 8-bit saturating wait counter per requester.
  - The counter increments each cycle `req_valid[i]`=1 and `req_ready[i]`=0.
  - It clears when `req_valid[i]`=0 or on acceptance of i.
  - `starve_flag[i]` sets when the counter reaches STARVE_LIMIT. It is sticky until `rst`.
- **Undefined:** `starve_flag` is tied to 0 and no counters exist.
- Arbitration and datapath behaviour are identical in both builds.

## Test plan
- **Reset:** assert `rst` mid-stream → all outputs are 0, `busy`=0, and the next grant with all requesters valid goes to requester 0.
- **Single request:** requester 1 issues A=3, B=4, op=00 at edge t, with a behavioural ALU model and `rsp_ready`=1 → `rsp_valid` after edge t+6 with `rsp_id`=1, result=7, carry=0, zero=0, overflow=0.
- **Contention:** all four requesters held valid, each with a distinct opcode → grant order 0,1,2,3,0. Consecutive accepts are exactly 8 cycles apart, and each response tag and result matches its requester.
- **Backpressure and flags:** hold `rsp_ready`=0 for 5 cycles during RESP on A=F, B=1, op=00 → `rsp_valid`, result=0, carry=1 and zero=1 stay stable all 5 cycles. No new `req_ready` is asserted until the handshake edge.
- **Reset mid-HOLD:** assert `rst` 2 cycles after an accept → no response ever appears for that operation, and `alu_a`/`alu_b`/`alu_op` read 0.
- **Starvation (macro on, STARVE_LIMIT=16):** requester 2 is valid while requester 0 is in RESP with `rsp_ready` held low for 20 cycles → `starve_flag[2]`=1 and stays set after requester 2 is served.
